// File: rtl/stoch_signed_decoder.sv
// stoch_signed_decoder
// Turns NUM_CH split-unipolar signed bitstream pairs (p, m) into signed
// binary counts. Each channel adds p - m over a window of 2^WINDOW_LOG2
// valid samples. Each result is held in a one-deep output register with a
// valid/ready handshake. Note: nRST is an active-high asynchronous reset,
// despite its name.
module stoch_signed_decoder #(
  parameter int NUM_CH      = 16,
  parameter int WINDOW_LOG2 = 8,
  parameter bit CONTINUOUS  = 1'b0
) (
  input  logic                                CLK,
  input  logic                                nRST,
  input  logic                                start,
  input  logic                                en,
  input  logic [NUM_CH-1:0]                   x_p,
  input  logic [NUM_CH-1:0]                   x_m,
  output logic [NUM_CH*(WINDOW_LOG2+2)-1:0]   y,
  output logic                                y_valid,
  input  logic                                y_ready,
  output logic                                busy,
  output logic                                overrun
);

  // A full window of +1 (or -1) samples reaches +/-2^WINDOW_LOG2, so two
  // extra bits are needed: one for the top value and one for the sign.
  localparam int OUT_W = WINDOW_LOG2 + 2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  logic [0:0]                   state_q,   state_d;
  logic [WINDOW_LOG2-1:0]       cnt_q,     cnt_d;
  logic [NUM_CH-1:0][OUT_W-1:0] acc_q,     acc_d;
  logic [NUM_CH-1:0][OUT_W-1:0] acc_next;
  logic [NUM_CH*OUT_W-1:0]      y_q,       y_d;
  logic                         y_valid_q, y_valid_d;
  logic                         busy_q,    busy_d;
  logic                         overrun_q, overrun_d;
  logic                         load;

  // Signed contribution of one (p, m) sample: +1, -1 or 0 (p=m cancels).
  function automatic logic [OUT_W-1:0] sample_delta(input logic p, input logic m);
    logic [OUT_W-1:0] d;
    case ({p, m})
      2'b10:   d = {{(OUT_W-1){1'b0}}, 1'b1};
      2'b01:   d = {OUT_W{1'b1}};
      default: d = {OUT_W{1'b0}};
    endcase
    return d;
  endfunction

  // Compute each channel's accumulator value including this cycle's sample.
  always_comb begin
    acc_next = acc_q;
    for (int i = 0; i < NUM_CH; i++) begin
      acc_next[i] = acc_q[i] + sample_delta(x_p[i], x_m[i]);
    end
  end

  // Next-state logic for the FSM, the window counter, the accumulators and
  // the output handshake.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    overrun_d = 1'b0;
    load      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Any sample present on the start cycle is deliberately dropped.
          state_d = ST_ACCUM;
          cnt_d   = {WINDOW_LOG2{1'b0}};
          acc_d   = {(NUM_CH*OUT_W){1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (en) begin
          if (&cnt_q) begin
            // Last sample of the window: publish it and clear for the next window.
            load    = 1'b1;
            y_d     = acc_next;
            acc_d   = {(NUM_CH*OUT_W){1'b0}};
            cnt_d   = {WINDOW_LOG2{1'b0}};
            state_d = CONTINUOUS ? ST_ACCUM : ST_IDLE;
          end else begin
            acc_d = acc_next;
            cnt_d = cnt_q + {{(WINDOW_LOG2-1){1'b0}}, 1'b1};
          end
        end else begin
          // Gap cycle: nothing advances.
          state_d = ST_ACCUM;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new load always wins. It flags an overrun only when the previous
    // result is being dropped without ever having been transferred.
    if (load) begin
      y_valid_d = 1'b1;
      overrun_d = y_valid_q & ~y_ready;
    end else if (y_valid_q && y_ready) begin
      y_valid_d = 1'b0;
    end else begin
      y_valid_d = y_valid_q;
    end

    busy_d = (state_d == ST_ACCUM);
  end

  // State registers. An asynchronous reset discards any partial window.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {WINDOW_LOG2{1'b0}};
      acc_q     <= {(NUM_CH*OUT_W){1'b0}};
      y_q       <= {(NUM_CH*OUT_W){1'b0}};
      y_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_stoch_signed_decoder.sv
// Directed testbench for stoch_signed_decoder with NUM_CH=2, WINDOW_LOG2=4.
// dut_a (CONTINUOUS=0) is driven from a cycle-by-cycle vector table.
// dut_b (CONTINUOUS=1) is driven by a hand-written sequence.
module tb_stoch_signed_decoder;

  localparam int NCH = 2;
  localparam int WL  = 4;
  localparam int YW  = NCH * (WL + 2);

  // Expected packed results, written as {ch1, ch0}.
  localparam logic [YW-1:0] Y_FULL  = 12'b110000_010000; // ch0=+16 ch1=-16
  localparam logic [YW-1:0] Y_CANC  = 12'b001000_000000; // ch0=0   ch1=+8
  localparam logic [YW-1:0] Y_NEG   = 12'b000000_110000; // ch0=-16 ch1=0
  localparam logic [YW-1:0] Y_POS0  = 12'b000000_010000; // ch0=+16 ch1=0
  localparam logic [YW-1:0] Y_ZERO  = 12'b000000_000000;

  logic CLK;
  logic nRST;

  logic            a_start, a_en, a_ready;
  logic [NCH-1:0]  a_xp, a_xm;
  logic [YW-1:0]   a_y;
  logic            a_valid, a_busy, a_ovr;

  logic            b_start, b_en, b_ready;
  logic [NCH-1:0]  b_xp, b_xm;
  logic [YW-1:0]   b_y;
  logic            b_valid, b_busy, b_ovr;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic           rst;
    logic           start;
    logic           en;
    logic [NCH-1:0] xp;
    logic [NCH-1:0] xm;
    logic           rdy;
    logic           e_valid;
    logic           e_busy;
    logic           e_ovr;
    logic           chk_y;
    logic [YW-1:0]  e_y;
  } vec_t;

  vec_t vecs[$];

  stoch_signed_decoder #(.NUM_CH(NCH), .WINDOW_LOG2(WL), .CONTINUOUS(1'b0)) dut_a (
    .CLK(CLK), .nRST(nRST), .start(a_start), .en(a_en),
    .x_p(a_xp), .x_m(a_xm), .y(a_y), .y_valid(a_valid),
    .y_ready(a_ready), .busy(a_busy), .overrun(a_ovr)
  );

  stoch_signed_decoder #(.NUM_CH(NCH), .WINDOW_LOG2(WL), .CONTINUOUS(1'b1)) dut_b (
    .CLK(CLK), .nRST(nRST), .start(b_start), .en(b_en),
    .x_p(b_xp), .x_m(b_xm), .y(b_y), .y_valid(b_valid),
    .y_ready(b_ready), .busy(b_busy), .overrun(b_ovr)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic start, input logic en,
                     input logic [NCH-1:0] xp, input logic [NCH-1:0] xm, input logic rdy,
                     input logic ev, input logic eb, input logic eo,
                     input logic cy, input logic [YW-1:0] ey);
    vec_t v;
    v.rst = rst; v.start = start; v.en = en; v.xp = xp; v.xm = xm; v.rdy = rdy;
    v.e_valid = ev; v.e_busy = eb; v.e_ovr = eo; v.chk_y = cy; v.e_y = ey;
    vecs.push_back(v);
  endtask

  // Advance one clock and sample 1 time unit after the active edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b1;
    a_start = 1'b0; a_en = 1'b0; a_ready = 1'b0; a_xp = '0; a_xm = '0;
    b_start = 1'b0; b_en = 1'b0; b_ready = 1'b0; b_xp = '0; b_xm = '0;

    // ---------------- vector table for dut_a ----------------
    // Reset state.
    for (int i = 0; i < 2; i++) add(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, Y_ZERO);
    add(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, Y_ZERO);

    // Full scale: ch0 always p, ch1 always m.
    add(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, Y_ZERO);
    for (int s = 0; s < 16; s++)
      add(1'b0, 1'b0, 1'b1, 2'b01, 2'b10, 1'b0, s == 15, s != 15, 1'b0, s == 15, Y_FULL);
    // Handshake hold: y_ready low for 10 cycles. Samples arriving while idle are ignored.
    for (int s = 0; s < 10; s++)
      add(1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, Y_FULL);
    add(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, Y_ZERO);

    // Cancellation with gaps. ch0 has p=m=1 throughout.
    // ch1 has p on 12 samples and m on the last 4.
    add(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, Y_ZERO);
    for (int s = 0; s < 16; s++) begin
      add(1'b0, 1'b0, 1'b1, {s < 12, 1'b1}, {s >= 12, 1'b1}, 1'b1,
          s == 15, s != 15, 1'b0, s == 15, Y_CANC);
      if (s != 15)
        add(1'b0, s == 5, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, Y_ZERO);
    end
    add(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, Y_CANC);
    add(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, Y_ZERO);

    // Reset mid-window after 7 samples.
    add(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, Y_ZERO);
    for (int s = 0; s < 7; s++)
      add(1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, Y_ZERO);
    for (int s = 0; s < 2; s++)
      add(1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, Y_ZERO);
    add(1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, Y_ZERO);
    // Start with a sample on the same cycle; that sample must not be counted.
    add(1'b0, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, Y_ZERO);
    for (int s = 0; s < 16; s++)
      add(1'b0, (s % 4) == 1, 1'b1, 2'b00, 2'b01, 1'b0,
          s == 15, s != 15, 1'b0, 1'b1, (s == 15) ? Y_NEG : Y_ZERO);
    add(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, Y_ZERO);

    // Apply the table one cycle per vector.
    foreach (vecs[k]) begin
      nRST    = vecs[k].rst;
      a_start = vecs[k].start;
      a_en    = vecs[k].en;
      a_xp    = vecs[k].xp;
      a_xm    = vecs[k].xm;
      a_ready = vecs[k].rdy;
      tick();
      chk($sformatf("a_valid[%0d]", k), {31'd0, a_valid}, {31'd0, vecs[k].e_valid});
      chk($sformatf("a_busy[%0d]", k), {31'd0, a_busy}, {31'd0, vecs[k].e_busy});
      chk($sformatf("a_overrun[%0d]", k), {31'd0, a_ovr}, {31'd0, vecs[k].e_ovr});
      if (vecs[k].chk_y)
        chk($sformatf("a_y[%0d]", k), {20'd0, a_y}, {20'd0, vecs[k].e_y});
    end
    nRST = 1'b0; a_start = 1'b0; a_en = 1'b0; a_ready = 1'b0;

    // ---------------- continuous mode on dut_b ----------------
    tick();
    chk("b_idle_valid", {31'd0, b_valid}, 32'd0);
    chk("b_idle_busy", {31'd0, b_busy}, 32'd0);
    b_start = 1'b1;
    tick();
    chk("b_start_busy", {31'd0, b_busy}, 32'd1);
    b_start = 1'b0;
    // Windows end at samples 16, 32 and 48. The load at sample 32 overruns
    // because y_ready is low. At sample 48, y_ready rises on the load cycle
    // itself, so the transfer and the load coincide.
    for (int k = 1; k <= 49; k++) begin
      logic           ev;
      logic [YW-1:0]  ey;
      b_en    = 1'b1;
      b_xp    = 2'b01;
      b_xm    = (k >= 33) ? 2'b10 : 2'b00;
      b_ready = (k >= 48);
      b_start = (k == 20);
      tick();
      ev = (k >= 16) && (k <= 48);
      ey = (k < 16) ? Y_ZERO : ((k >= 48) ? Y_FULL : Y_POS0);
      chk($sformatf("b_valid[%0d]", k), {31'd0, b_valid}, {31'd0, ev});
      chk($sformatf("b_overrun[%0d]", k), {31'd0, b_ovr}, {31'd0, k == 32});
      chk($sformatf("b_busy[%0d]", k), {31'd0, b_busy}, 32'd1);
      chk($sformatf("b_y[%0d]", k), {20'd0, b_y}, {20'd0, ey});
    end
    b_en = 1'b0; b_ready = 1'b0; b_start = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
